// File: rtl/solar_pkg.sv
// Shared types and constants for the solar tracker scan sequencer.
package solar_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CHAN_W = 2;

  localparam logic [DATA_W-1:0] TH_DEFAULT = 8'd10;

  localparam logic [CHAN_W-1:0] CH_N = 2'd0;
  localparam logic [CHAN_W-1:0] CH_E = 2'd1;
  localparam logic [CHAN_W-1:0] CH_S = 2'd2;
  localparam logic [CHAN_W-1:0] CH_W = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_STORE,
    ST_EVAL
  } scan_state_e;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_N,
    DIR_E,
    DIR_S,
    DIR_W
  } dir_e;

  typedef struct packed {
    logic [DATA_W-1:0] n;
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] w;
  } readings_t;

  // Motor enable vector ordered {w, s, e, n}; at most one bit set.
  function automatic logic [3:0] dir_onehot(input dir_e d);
    logic [3:0] oh;
    oh = 4'b0000;
    case (d)
      DIR_N:   oh = 4'b0001;
      DIR_E:   oh = 4'b0010;
      DIR_S:   oh = 4'b0100;
      DIR_W:   oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/solar_scan_ctrl_if.sv
// ADC start/done handshake between the scan controller and the converter.
interface solar_scan_ctrl_if;
  import solar_pkg::*;

  logic              adc_start;
  logic [CHAN_W-1:0] adc_ch;
  logic              adc_done;
  logic [DATA_W-1:0] adc_data;

  modport master (output adc_start, output adc_ch, input adc_done, input adc_data);
  modport slave  (input adc_start, input adc_ch, output adc_done, output adc_data);
endinterface

// File: rtl/solar_dir_eval.sv
// Combinational motor-direction decision: threshold start from rest, hysteresis stop.
module solar_dir_eval
  import solar_pkg::*;
(
  input  readings_t         rd,
  input  dir_e              dir,
  input  logic [DATA_W-1:0] th,
  output dir_e              next_dir_c
);

  // Zero-extended so sensor + threshold can never wrap.
  logic [DATA_W:0] n9, e9, s9, w9, th9;

  always_comb begin
    n9  = {1'b0, rd.n};
    e9  = {1'b0, rd.e};
    s9  = {1'b0, rd.s};
    w9  = {1'b0, rd.w};
    th9 = {1'b0, th};
    next_dir_c = dir;
    case (dir)
      DIR_NONE: begin
        if (n9 > s9 + th9)      next_dir_c = DIR_N;
        else if (e9 > w9 + th9) next_dir_c = DIR_E;
        else if (s9 > n9 + th9) next_dir_c = DIR_S;
        else if (w9 > e9 + th9) next_dir_c = DIR_W;
      end
      DIR_N:   if (n9 <= s9) next_dir_c = DIR_NONE;
      DIR_E:   if (e9 <= w9) next_dir_c = DIR_NONE;
      DIR_S:   if (s9 <= n9) next_dir_c = DIR_NONE;
      DIR_W:   if (w9 <= e9) next_dir_c = DIR_NONE;
      default: next_dir_c = DIR_NONE;
    endcase
  end

endmodule

// File: rtl/solar_scan_ctrl.sv
// Four-sensor ADC scan sequencer with single-motor scheduling, run-time limit and sticky fault.
module solar_scan_ctrl
  import solar_pkg::*;
#(
  parameter logic [DATA_W-1:0] TH       = TH_DEFAULT,
  parameter int unsigned       SCAN_DIV = 1000,
  parameter int unsigned       ADC_TO   = 255,
  parameter int unsigned       MOVE_MAX = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  solar_scan_ctrl_if.master        adc,
  output logic [DATA_W-1:0]        lsn,
  output logic [DATA_W-1:0]        lse,
  output logic [DATA_W-1:0]        lss,
  output logic [DATA_W-1:0]        lsw,
  output logic                     sample_valid,
  output logic                     mn,
  output logic                     me,
  output logic                     ms,
  output logic                     mw,
  output logic                     fault
);

  localparam int unsigned TMR_W  = $clog2(SCAN_DIV + 1);
  localparam int unsigned WAIT_W = $clog2(ADC_TO + 1);
  localparam int unsigned MOVE_W = $clog2(MOVE_MAX + 1);

  scan_state_e       state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [MOVE_W-1:0] move_q, move_d;
  logic [CHAN_W-1:0] ch_q, ch_d;
  readings_t         rd_q, rd_d;
  dir_e              dir_q, dir_d;
  logic [3:0]        mot_q, mot_d;
  logic              start_q, start_d;
  logic              sv_q, sv_d;
  logic              fault_q, fault_d;
  dir_e              eval_dir_c;

  solar_dir_eval u_dir_eval (
    .rd         (rd_q),
    .dir        (dir_q),
    .th         (TH),
    .next_dir_c (eval_dir_c)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    wait_d  = wait_q;
    ch_d    = ch_q;
    rd_d    = rd_q;
    dir_d   = dir_q;
    fault_d = fault_q;
    start_d = 1'b0;
    sv_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (timer_q == TMR_W'(SCAN_DIV - 1)) begin
          timer_d = '0;
          ch_d    = CH_N;
          start_d = 1'b1;
          state_d = ST_REQ;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_REQ: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (adc.adc_done) begin
          case (ch_q)
            CH_N:    rd_d.n = adc.adc_data;
            CH_E:    rd_d.e = adc.adc_data;
            CH_S:    rd_d.s = adc.adc_data;
            default: rd_d.w = adc.adc_data;
          endcase
          state_d = ST_STORE;
        end else if (wait_q == WAIT_W'(ADC_TO - 1)) begin
          // Converter never answered: keep what was stored, drop the scan.
          fault_d = 1'b1;
          dir_d   = DIR_NONE;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_STORE: begin
        if (ch_q == CH_W) begin
          state_d = ST_EVAL;
        end else begin
          ch_d    = ch_q + CHAN_W'(1);
          start_d = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_EVAL: begin
        sv_d    = 1'b1;
        dir_d   = fault_q ? DIR_NONE : eval_dir_c;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Run-time limit wins over any same-cycle evaluation result.
    if ((dir_q != DIR_NONE) && (move_q == MOVE_W'(MOVE_MAX - 1))) begin
      dir_d   = DIR_NONE;
      fault_d = 1'b1;
    end

    move_d = ((dir_d != dir_q) || (dir_q == DIR_NONE)) ? '0 : move_q + MOVE_W'(1);
    mot_d  = dir_onehot(dir_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      wait_q  <= '0;
      move_q  <= '0;
      ch_q    <= CH_N;
      rd_q    <= '0;
      dir_q   <= DIR_NONE;
      mot_q   <= '0;
      start_q <= 1'b0;
      sv_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wait_q  <= wait_d;
      move_q  <= move_d;
      ch_q    <= ch_d;
      rd_q    <= rd_d;
      dir_q   <= dir_d;
      mot_q   <= mot_d;
      start_q <= start_d;
      sv_q    <= sv_d;
      fault_q <= fault_d;
    end
  end

  assign adc.adc_start = start_q;
  assign adc.adc_ch    = ch_q;
  assign lsn           = rd_q.n;
  assign lse           = rd_q.e;
  assign lss           = rd_q.s;
  assign lsw           = rd_q.w;
  assign sample_valid  = sv_q;
  assign mn            = mot_q[0];
  assign me            = mot_q[1];
  assign ms            = mot_q[2];
  assign mw            = mot_q[3];
  assign fault         = fault_q;

endmodule

// File: tb/tb_solar_scan_ctrl.sv
// Self-checking bench for solar_scan_ctrl: ADC responder plus a scan-schedule / decision-rule reference.
module tb_solar_scan_ctrl;

  localparam int TH       = 10;
  localparam int SCAN_DIV = 8;
  localparam int ADC_TO   = 16;
  localparam int MOVE_MAX = 64;
  localparam int ADC_LAT  = 3;
  localparam int CH_SLOT  = 2 + ADC_LAT;
  localparam int SCAN_LEN = 4 * CH_SLOT + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lsn, lse, lss, lsw;
  logic       sample_valid, mn, me, ms, mw, fault;

  solar_scan_ctrl_if adc_if ();

  solar_scan_ctrl #(
    .TH       (8'(TH)),
    .SCAN_DIV (SCAN_DIV),
    .ADC_TO   (ADC_TO),
    .MOVE_MAX (MOVE_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .adc          (adc_if),
    .lsn          (lsn),
    .lse          (lse),
    .lss          (lss),
    .lsw          (lsw),
    .sample_valid (sample_valid),
    .mn           (mn),
    .me           (me),
    .ms           (ms),
    .mw           (mw),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int next_base;
  int scene [4];
  int suppress_ch = -1;
  bit spur_req = 1'b0;
  int pend = 0;
  int pend_ch = 0;
  int m_dir, m_fault, m_start;
  int m_rd [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int decide(input int dir, input int n, input int e, input int s, input int w);
    int r;
    r = dir;
    case (dir)
      0: begin
        if (n > s + TH)      r = 1;
        else if (e > w + TH) r = 2;
        else if (s > n + TH) r = 3;
        else if (w > e + TH) r = 4;
      end
      1: if (n <= s) r = 0;
      2: if (e <= w) r = 0;
      3: if (s <= n) r = 0;
      4: if (w <= e) r = 0;
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] mot_vec(input int d);
    case (d)
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0100;
      4: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // ADC responder: answers ADC_LAT cycles after adc_start unless that channel is suppressed.
  initial begin
    adc_if.adc_done = 1'b0;
    adc_if.adc_data = 8'h00;
    forever begin
      @(negedge clk);
      adc_if.adc_done = 1'b0;
      if (rst) begin
        pend = 0;
      end else begin
        if (spur_req) begin
          adc_if.adc_done = 1'b1;
          adc_if.adc_data = 8'hA5;
          spur_req = 1'b0;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0 && pend_ch != suppress_ch) begin
            adc_if.adc_done = 1'b1;
            adc_if.adc_data = 8'(scene[pend_ch]);
          end
        end
        if (adc_if.adc_start) begin
          pend    = ADC_LAT;
          pend_ch = int'(adc_if.adc_ch);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk(tag, {adc_if.adc_start, adc_if.adc_ch, lsn, lse, lss, lsw,
              sample_valid, mn, me, ms, mw, fault}, 64'd0);
  endtask

  // Holds rst for three cycles, then releases it; cycle 1 is the first cycle with rst low.
  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_all_zero("reset_hold");
    end
    rst = 1'b0;
    cyc = 1;
    next_base = SCAN_DIV + 1;
    m_dir = 0; m_fault = 0; m_start = 0;
    for (int i = 0; i < 4; i++) m_rd[i] = 0;
    suppress_ch = -1;
    chk_all_zero("reset_release");
  endtask

  // One scan, checked every cycle. to_ch >= 0 withholds that channel's reply; abort_at > 0 stops early.
  task automatic do_scan(input int n, input int e, input int s, input int w,
                         input int to_ch, input int abort_at, input bit spur);
    int base, last, endc;
    bit done_scan;
    base = next_base;
    scene[0] = n; scene[1] = e; scene[2] = s; scene[3] = w;
    suppress_ch = to_ch;
    last = (to_ch < 0) ? 3 : to_ch;
    endc = (to_ch < 0) ? base + SCAN_LEN : base + CH_SLOT * to_ch + ADC_TO + 1;
    if (abort_at > 0) endc = abort_at;
    while (cyc < endc) begin
      @(negedge clk);
      cyc++;
      if (spur && cyc == base - 4) spur_req = 1'b1;
      if (m_dir != 0 && cyc >= m_start + MOVE_MAX) begin
        m_dir = 0;
        m_fault = 1;
      end
      done_scan = (cyc == endc) && (abort_at == 0);
      if (done_scan) begin
        if (to_ch < 0) begin
          for (int i = 0; i < 4; i++) m_rd[i] = scene[i];
          if (m_fault == 0) begin
            int nd;
            nd = decide(m_dir, m_rd[0], m_rd[1], m_rd[2], m_rd[3]);
            if (nd != m_dir) begin
              m_dir = nd;
              m_start = cyc;
            end
          end
        end else begin
          for (int i = 0; i < to_ch; i++) m_rd[i] = scene[i];
          m_fault = 1;
          m_dir = 0;
        end
      end
      chk("adc_start", adc_if.adc_start,
          (cyc >= base) && (cyc <= base + CH_SLOT * last) && ((cyc - base) % CH_SLOT == 0));
      if (cyc >= base && cyc < base + CH_SLOT * (last + 1) && cyc < endc)
        chk("adc_ch", adc_if.adc_ch, (cyc - base) / CH_SLOT);
      chk("sample_valid", sample_valid, done_scan && (to_ch < 0));
      chk("motors", {mw, ms, me, mn}, mot_vec(m_dir));
      chk("fault", fault, m_fault != 0);
      if (done_scan) begin
        chk("lsn", lsn, m_rd[0]);
        chk("lse", lse, m_rd[1]);
        chk("lss", lss, m_rd[2]);
        chk("lsw", lsw, m_rd[3]);
      end
    end
    next_base = endc + SCAN_DIV;
  endtask

  initial begin
    rst = 1'b1;

    // Start, hysteresis, threshold, priority and width cases.
    apply_reset();
    do_scan(100, 50,  80,  50, -1, 0, 1'b0);
    do_scan( 85, 50,  80,  50, -1, 0, 1'b0);
    do_scan( 80, 50,  80,  50, -1, 0, 1'b0);
    do_scan( 90, 50,  80,  50, -1, 0, 1'b0);
    do_scan( 50, 200, 20,  10, -1, 0, 1'b0);
    do_scan( 10, 50,  20,  50, -1, 0, 1'b0);
    do_scan(255, 50, 250,  50, -1, 0, 1'b0);
    do_scan(  0,  0,   0, 255, -1, 0, 1'b0);
    do_scan(  0, 100,  0, 100, -1, 0, 1'b0);

    // ADC timeout on channel 2, then a strong N scene while faulted.
    apply_reset();
    do_scan( 30, 40,  35,  45, -1, 0, 1'b0);
    do_scan( 11, 22,  33,  44,  2, 0, 1'b0);
    do_scan(200, 50,   0,  50, -1, 0, 1'b0);

    // Randomized scenes against the reference rules.
    apply_reset();
    for (int k = 0; k < 14; k++) begin
      int v [4];
      for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(255, 0));
      if (k % 3 == 1) v[2] = v[0] - 5 + int'($urandom_range(10, 0));
      if (v[2] < 0) v[2] = 0;
      if (v[2] > 255) v[2] = 255;
      do_scan(v[0], v[1], v[2], v[3], -1, 0, k[0]);
    end

    // Sustained move hits the run-time limit; spurious adc_done during idle.
    apply_reset();
    do_scan(200, 50, 0, 50, -1, 0, 1'b1);
    do_scan(200, 50, 0, 50, -1, 0, 1'b1);
    do_scan(200, 50, 0, 50, -1, 0, 1'b1);
    do_scan(200, 50, 0, 50, -1, 0, 1'b0);

    // Reset while waiting on the converter with the N motor running.
    apply_reset();
    do_scan(200, 50, 0, 50, -1, 0, 1'b0);
    do_scan(200, 50, 0, 50, -1, next_base + 1, 1'b0);
    chk("mid_move_mn", mn, 1'b1);
    apply_reset();
    do_scan(120, 60, 60, 60, -1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/solar_scan_ctrl.md
Name: solar_scan_ctrl

Overview:
Scan sequencer and motor scheduler for the four-quadrant solar tracker. It time-shares one 8-bit ADC across the N/E/S/W light sensors using a start/done handshake and holds the latest readings. After each full scan it decides a single motor direction, using hysteresis, a run-time limit and a sticky fault. It sits between the ADC front end and the four motor drivers.

Parameters:
TH, 8'd10, start threshold: a sensor must exceed its opposite by strictly more than TH.
SCAN_DIV, 1000, idle cycles between scans (>=1).
ADC_TO, 255, cycles allowed in WAIT for adc_done before an ADC fault.
MOVE_MAX, 50000, maximum cycles a motor may stay on before a move fault.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
adc_start  out  1  one-cycle conversion request.
adc_ch  out  2  channel select, 0=N 1=E 2=S 3=W; stable from REQ until the sample is stored.
adc_done  in  1  one-cycle pulse, adc_data valid.
adc_data  in  8  conversion result.
lsn, lse, lss, lsw  out  8 each  latest stored readings.
sample_valid  out  1  one-cycle pulse after a complete scan is evaluated.
mn, me, ms, mw  out  1 each  motor enables, at most one high (one-hot or all zero).
fault  out  1  sticky fault flag.

Behaviour:
- Reset: all outputs 0, readings 0, motor dir NONE, fault 0, scan timer 0, FSM IDLE, adc_ch 0. rst mid-scan or mid-move aborts immediately, with no final sample or motor pulse.
- Scan FSM: IDLE -> REQ -> WAIT -> STORE -> (REQ | EVAL) -> IDLE.
- IDLE: timer counts up; at SCAN_DIV-1 clear the timer, set ch=0, go to REQ. The first adc_start is SCAN_DIV+1 cycles after rst falls.
- REQ: adc_start=1 for exactly one cycle; go to WAIT; clear the WAIT counter.
- WAIT: adc_done is sampled only in this state; adc_done in any other state is ignored.
  - On adc_done, capture adc_data into the channel's register; go to STORE.
  - If the counter reaches ADC_TO without adc_done: fault<=1, motors off, abandon the scan (readings already stored are kept), go to IDLE.
- STORE: ch==3 -> EVAL, else ch+1 -> REQ. Scan length = 4*(2+ADC latency)+1 cycles.
- EVAL (one cycle):
  - All comparisons use 9-bit zero-extended arithmetic; no wrap-around.
  - Start is decided only when dir==NONE and fault==0, priority N>E>S>W:
    - N if lsn > lss+TH
    - E if lse > lsw+TH
    - S if lss > lsn+TH
    - W if lsw > lse+TH
  - Stop (hysteresis) when the current dir's sensor <= its opposite:
    - N stops when lsn<=lss; E when lse<=lsw; S when lss<=lsn; W when lsw<=lse.
  - A stop and a new start never occur in the same EVAL; restart is decided at the next scan earliest.
  - The dir register and sample_valid update on the EVAL->IDLE edge. New motor outputs are visible in the same cycle sample_valid is high.
- Motor run counter:
  - Clears on every dir change and counts while dir!=NONE.
  - On reaching MOVE_MAX-1: dir<=NONE, fault<=1. This overrides any same-cycle EVAL start/continue.
- Fault:
  - Sticky until rst.
  - While fault=1, scans continue and readings and sample_valid still update, but dir is forced to NONE.
- Motor outputs are decoded from the registered dir, so they are glitch-free.

Decomposition:
- Package solar_pkg holds:
  - scan FSM state encodings (IDLE, REQ, WAIT, STORE, EVAL)
  - channel codes CH_N/E/S/W
  - motor dir encoding (NONE, N, E, S, W), reused from the tracker's state set
  - default TH
- Sub-module solar_dir_eval: a purely combinational decision taking the four readings, the current dir and TH, and returning next_dir. Unit-testable alone.
- Timers and the FSM live in solar_scan_ctrl.

Test Plan:
Bench settings: SCAN_DIV=8, ADC_TO=16, MOVE_MAX=64; ADC model replies 3 cycles after adc_start.
- Reset/first scan: release rst -> all outputs 0; adc_start pulses with adc_ch 0,1,2,3 in order; first adc_start 9 cycles after rst falls; sample_valid pulses once per scan.
- Start/hysteresis: scan N=100,E=50,S=80,W=50 -> mn=1. Next N=85,S=80 -> mn stays 1. Next N=80,S=80 -> mn=0, no other motor.
- Threshold/priority/width: N=90,S=80 -> no motor (not strictly >). N=50,S=20,E=200,W=10 -> mn only. N=255,S=250 -> no motor (no 8-bit wrap). S=0,N=0,W=255,E=0 -> mw.
- ADC timeout: suppress adc_done on ch 2 -> fault=1 at WAIT count 16, lsn/lse updated, lss/lsw unchanged. Next scan proceeds; motors stay 0 with N=200,S=0.
- Move timeout: hold N=200,S=0 -> mn high exactly 64 cycles, then mn=0 and fault=1. Spurious adc_done in IDLE has no effect.
- Reset mid-operation: assert rst during WAIT while mn=1 -> next cycle all outputs 0, fault 0, FSM IDLE; no sample_valid.
